// File: rtl/ss_mux_if.sv
// Connection bundle between the time-keeping logic and ss_mux_driver.
// It carries the digit data and controls in, and the display pin drives out.
interface ss_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    lz_suppress;
    logic                    load;
    logic [6:0]              a_to_g;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output digits, dp_in, blank_mask, lz_suppress, load,
        input  a_to_g, dp, an, frame_done
    );

    modport slave (
        input  digits, dp_in, blank_mask, lz_suppress, load,
        output a_to_g, dp, an, frame_done
    );
endinterface

// File: rtl/ss_mux_driver.sv
// N-digit multiplexed seven-segment driver: hex decode, anode scanning with an
// anti-ghost blank interval, frame-aligned double buffering and leading-zero blanking.
module ss_mux_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic    clk,
    input  logic    rst_n,
    ss_mux_if.slave bus
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      BLANK_LIM = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF    = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW}};

    typedef enum logic {
        SLOT_BLANK = 1'b0,
        SLOT_ON    = 1'b1
    } slot_e;

    localparam slot_e SLOT_RST = (BLANK_CYCLES > 0) ? SLOT_BLANK : SLOT_ON;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blank;
    } frame_t;

    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [IDX_W-1:0]      idx, idx_next;
    slot_e                 state, state_next;
    logic                  frame_end;
    frame_t                pend, act;

    logic [NUM_DIGITS-1:0] lz_dark;
    logic [3:0]            cur_nib;
    logic [6:0]            seg_on;
    logic                  dp_on;
    logic [NUM_DIGITS-1:0] an_on;

    logic [6:0]            a_to_g_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic                  frame_done_q;

    // Active-high segment pattern, a = bit 6 .. g = bit 0.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'b1111110;
            4'h1:    return 7'b0110000;
            4'h2:    return 7'b1101101;
            4'h3:    return 7'b1111001;
            4'h4:    return 7'b0110011;
            4'h5:    return 7'b1011011;
            4'h6:    return 7'b1011111;
            4'h7:    return 7'b1110000;
            4'h8:    return 7'b1111111;
            4'h9:    return 7'b1111011;
            4'hA:    return 7'b1110111;
            4'hB:    return 7'b0011111;
            4'hC:    return 7'b1001110;
            4'hD:    return 7'b0111101;
            4'hE:    return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    // Scan counters and slot state; the slot state always matches the cnt it is stored with.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cnt_next  = cnt + 1'b1;
        idx_next  = idx;
        frame_end = 1'b0;
        if (cnt == CNT_LAST) begin
            cnt_next = '0;
            if (idx == IDX_LAST) begin
                idx_next  = '0;
                frame_end = 1'b1;
            end else begin
                idx_next = idx + 1'b1;
            end
        end
        state_next = (cnt_next < BLANK_LIM) ? SLOT_BLANK : SLOT_ON;
    end

    // A digit is suppressed when it and every digit to its left hold zero; digit 0 never is.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_dark    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (act.digits[4*i +: 4] == 4'h0);
            lz_dark[i] = bus.lz_suppress & zero_above & (i != 0);
        end
    end

    assign cur_nib = act.digits[{idx, 2'b00} +: 4];

    always_comb begin
        seg_on = 7'b0;
        dp_on  = 1'b0;
        an_on  = '0;
        if (state == SLOT_ON) begin
            an_on = NUM_DIGITS'(1) << idx;
            // Masked digits keep their anode so every digit gets the same duty cycle.
            if (!act.blank[idx]) begin
                dp_on = act.dp[idx];
                if (!lz_dark[idx]) begin
                    seg_on = decode(cur_nib);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            idx          <= '0;
            state        <= SLOT_RST;
            pend         <= '0;
            act          <= '0;
            a_to_g_q     <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cnt   <= cnt_next;
            idx   <= idx_next;
            state <= state_next;
            // A load on the boundary edge lands in pend only; act takes the older pend.
            if (frame_end) begin
                act <= pend;
            end
            if (bus.load) begin
                pend <= '{digits: bus.digits, dp: bus.dp_in, blank: bus.blank_mask};
            end
            a_to_g_q     <= seg_on ^ SEG_OFF;
            dp_q         <= dp_on ^ DP_OFF;
            an_q         <= an_on ^ AN_OFF;
            frame_done_q <= frame_end;
        end
    end

    assign bus.a_to_g     = a_to_g_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_ss_mux_driver.sv
// Self-checking bench for ss_mux_driver: directed scenarios plus random traffic, checked
// every cycle against a frame-position reference model.
module tb_ss_mux_driver;
    localparam int N  = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = N * RD;

    logic clk;
    logic rst_n;

    ss_mux_if #(.NUM_DIGITS(N)) bus ();

    ss_mux_driver #(
        .NUM_DIGITS    (N),
        .REFRESH_DIV   (RD),
        .BLANK_CYCLES  (BC),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Reference model: edges since reset release plus the two data buffers.
    int          m_e;
    logic [15:0] m_pend_dig, m_act_dig;
    logic [3:0]  m_pend_dp, m_act_dp, m_pend_blk, m_act_blk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_e        = 0;
        m_pend_dig = '0; m_act_dig = '0;
        m_pend_dp  = '0; m_act_dp  = '0;
        m_pend_blk = '0; m_act_blk = '0;
    endtask

    task automatic set_in(input logic [15:0] d, input logic [3:0] dpi, input logic [3:0] bm,
                          input logic lz, input logic ld);
        bus.digits      = d;
        bus.dp_in       = dpi;
        bus.blank_mask  = bm;
        bus.lz_suppress = lz;
        bus.load        = ld;
    endtask

    // One clock: predict what the coming edge registers, advance the model, then compare.
    task automatic tick();
        int         p, ix, cn;
        logic [6:0] e_seg;
        logic       e_dp, e_fd, zero_above;
        logic [3:0] e_an, nib;
        p     = m_e % FRAME;
        ix    = p / RD;
        cn    = p % RD;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_fd  = (p == FRAME - 1);
        if (cn >= BC) begin
            e_an = ~(4'b0001 << ix);
            nib  = m_act_dig[ix*4 +: 4];
            zero_above = 1'b1;
            for (int j = ix; j < N; j++)
                if (m_act_dig[j*4 +: 4] != 4'h0) zero_above = 1'b0;
            if (!m_act_blk[ix]) begin
                e_dp = ~m_act_dp[ix];
                if (!(bus.lz_suppress && ix != 0 && zero_above)) e_seg = ~seg_tab[nib];
            end
        end
        if (p == FRAME - 1) begin
            m_act_dig = m_pend_dig;
            m_act_dp  = m_pend_dp;
            m_act_blk = m_pend_blk;
        end
        if (bus.load) begin
            m_pend_dig = bus.digits;
            m_pend_dp  = bus.dp_in;
            m_pend_blk = bus.blank_mask;
        end
        m_e++;
        @(posedge clk);
        @(negedge clk);
        check("an", 32'(bus.an), 32'(e_an));
        check("a_to_g", 32'(bus.a_to_g), 32'(e_seg));
        check("dp", 32'(bus.dp), 32'(e_dp));
        check("frame_done", 32'(bus.frame_done), 32'(e_fd));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, 32'(bus.an), 32'h0000_000F);
        check({tag, "_a_to_g"}, 32'(bus.a_to_g), 32'h0000_007F);
        check({tag, "_dp"}, 32'(bus.dp), 32'h1);
        check({tag, "_frame_done"}, 32'(bus.frame_done), 32'h0);
    endtask

    initial begin
        logic [15:0] mask;
        rst_n = 1'b0;
        set_in(16'h0000, 4'h0, 4'h0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Power-up scan of the all-zero buffers, two full frames.
        run(2 * FRAME);

        // Mid-frame load must not disturb the frame in progress.
        run(12);
        set_in(16'h12AF, 4'h0, 4'h0, 1'b0, 1'b1);
        tick();
        bus.load = 1'b0;
        run(2 * FRAME);

        // Leading-zero suppression, then all zeros.
        set_in(16'h0040, 4'h0, 4'h0, 1'b1, 1'b1);
        tick();
        bus.load = 1'b0;
        run(2 * FRAME);
        set_in(16'h0000, 4'h0, 4'h0, 1'b1, 1'b1);
        tick();
        bus.load = 1'b0;
        run(2 * FRAME);

        // Per-digit blanking with dp, then dp on an unmasked digit.
        set_in(16'h1234, 4'b0100, 4'b0100, 1'b0, 1'b1);
        tick();
        bus.load = 1'b0;
        run(2 * FRAME);
        set_in(16'h1234, 4'b0010, 4'b0100, 1'b0, 1'b1);
        tick();
        bus.load = 1'b0;
        run(2 * FRAME);

        // Load on the frame-boundary edge itself.
        set_in(16'h5678, 4'b0001, 4'h0, 1'b0, 1'b1);
        tick();
        bus.load = 1'b0;
        while ((m_e % FRAME) != FRAME - 1) tick();
        set_in(16'h9ABC, 4'b1000, 4'h0, 1'b0, 1'b1);
        tick();
        bus.load = 1'b0;
        run(2 * FRAME);

        // Random traffic, biased toward leading zeros and occasional masks.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                3: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            set_in(16'($urandom) & mask, 4'($urandom),
                   ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                   1'($urandom), ($urandom_range(0, 7) == 0));
            tick();
        end
        bus.load = 1'b0;

        // Asynchronous reset during the ON phase of digit 2.
        set_in(16'hBEEF, 4'hF, 4'h0, 1'b0, 1'b1);
        tick();
        bus.load = 1'b0;
        while (((m_e - 1) % FRAME) != 2 * RD + 4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("held_reset");
        rst_n = 1'b1;
        run(2 * FRAME);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ss_mux_driver.md
Name: ss_mux_driver

Overview:
Parametrised N-digit multiplexed seven-segment display driver for the digital clock. It is the successor to the single-digit combinational decoders.
- Full hex decode (0-F) per digit.
- Time-multiplexed anode scanning with a per-slot blanking (anti-ghost) interval.
- Tear-free double-buffered digit load.
- Leading-zero suppression, per-digit blanking and decimal points.
- Sits between the time-keeping counters and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 100000, clk cycles per digit slot (>=2)
BLANK_CYCLES, 16, cycles at slot start with all anodes off (0..REFRESH_DIV-1)
SEG_ACTIVE_LOW, 1, 1: segment lit when its a_to_g/dp bit is 0
AN_ACTIVE_LOW, 1, 1: digit enabled when its an bit is 0

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
digits  input  4*NUM_DIGITS  hex nibbles; nibble i = digits[4i+3:4i], digit 0 rightmost
dp_in  input  NUM_DIGITS  decimal point request per digit
blank_mask  input  NUM_DIGITS  1 = force digit i dark
lz_suppress  input  1  1 = blank leading zeros
load  input  1  capture digits/dp_in/blank_mask into pending buffer
a_to_g  output  7  segments a..g, a = bit 6, g = bit 0
dp  output  1  decimal point segment
an  output  NUM_DIGITS  digit enables, an[i] drives digit i
frame_done  output  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset (async assert, sync release):
  - cnt=0, idx=0; pending and active buffers all 0.
  - an all inactive; a_to_g all segments off; dp off; frame_done=0.
  - "Off" means polarity-correct: with defaults, an=all 1, a_to_g=7'b1111111, dp=1.
- Counters:
  - cnt runs 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, idx increments 0..NUM_DIGITS-1 and wraps to 0.
  - Frame length = NUM_DIGITS*REFRESH_DIV cycles.
- Slot FSM per digit (derived from cnt):
  - BLANK when cnt<BLANK_CYCLES: all anodes inactive, segments off.
  - ON otherwise: an[idx] active, all others inactive.
  - BLANK_CYCLES=0 means no BLANK state.
- Output timing: all outputs are registered. Outputs in cycle t+1 reflect cnt/idx/active in cycle t.
- Buffering:
  - load=1 on an edge: pending <= {digits, dp_in, blank_mask}.
  - Frame boundary (edge with cnt=REFRESH_DIV-1 and idx=NUM_DIGITS-1): active <= pending, and frame_done is pulsed (1 in the following cycle).
  - If load coincides with the frame boundary, active takes the old pending value; the new data reaches active one frame later.
  - Displayed data never changes mid-frame.
- Decode (active-high pattern before polarity inversion):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- Leading-zero suppression: when lz_suppress=1, digit i is dark if digit i and every higher digit hold nibble 0. Digit 0 is never suppressed. dp_in of a suppressed digit still lights dp.
- blank_mask[i]=1 (active copy):
  - Segments and dp off for slot i.
  - an[i] still asserted, keeping the scan duty uniform.
- Polarity: SEG_ACTIVE_LOW inverts a_to_g and dp; AN_ACTIVE_LOW inverts an.
- lz_suppress is sampled live, not buffered.
- Reset mid-frame: outputs go to reset values immediately. Scan restarts at idx=0, cnt=0 after release.

Test Plan:
(Bench params: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, defaults otherwise.)
1. Reset release, no load -> an=1111 for cycles 1-2. Then an=1110 with a_to_g=0000001 ('0') for cycles 3-8. Then an=1101, and so on. frame_done pulses every 32 cycles.
2. load=1 with digits=16'h12AF, dp_in=0, blank_mask=0 mid-frame -> current frame unchanged. Next frame shows: digit 0 = 0111000 (F), digit 1 = 0001000 (A), digit 2 = 0010010 (2), digit 3 = 1001111 (1).
3. digits=16'h0040, lz_suppress=1 -> digits 3 and 2 dark with their an still pulsing. Digit 1 = 1001100 (4), digit 0 = 0000001 (0). With digits=16'h0000, only digit 0 is lit.
4. blank_mask=4'b0100, dp_in=4'b0100, digits=16'h1234 -> slot 2: an=1011, a_to_g=1111111, dp=1. Other slots are normal. dp_in=4'b0010 instead -> slot 1: dp=0.
5. load asserted exactly on the frame-boundary edge -> old pending is displayed for the next frame, new data the frame after.
6. rst_n pulled low during the ON phase of digit 2 -> an=1111, a_to_g=1111111 and frame_done=0 asynchronously. After release, the scan restarts from digit 0 with the blank phase.
